// File: rtl/i2c_target.sv
// i2c_target: 7-bit-address I2C target (responder).
// SCL/SDA are oversampled on mclk through 2-flop synchronizers plus an edge
// detector. Written bytes are delivered on rx_data/rx_valid; read bytes are
// requested with tx_req and taken from tx_data.
// Optional feature macro: I2C_TARGET_GENCALL_EN (ACK general-call write 8'h00).
`timescale 1ns/1ps

module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       SCL,
    input  logic       SDA_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_DATA,
        ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_WAIT_STOP
    } state_t;

    // Address byte match: own address (either direction), optionally general call write.
    function automatic logic addr_match(input logic [7:0] a);
        logic m;
        m = (a[7:1] == DEV_ADDR);
`ifdef I2C_TARGET_GENCALL_EN
        m = m | (a == 8'h00);
`else
        m = m | 1'b0;
`endif
        return m;
    endfunction

    logic [1:0] scl_sync_r, sda_sync_r;
    logic       scl_prev_r, sda_prev_r;
    logic       scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

    state_t     state_r, state_nxt_s;
    logic [3:0] bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0] shift_r, shift_nxt_s;
    logic [7:0] tx_shift_r, tx_shift_nxt_s;
    logic       rw_r, rw_nxt_s;
    logic       sda_oe_r, sda_oe_nxt_s;
    logic [7:0] rx_data_r, rx_data_nxt_s;
    logic       rx_valid_r, rx_valid_nxt_s;
    logic       tx_req_r, tx_req_nxt_s;
    logic       busy_r, busy_nxt_s;
    logic [7:0] addr_byte_s;

    // Synchronize the bus pins and keep one previous sample for edge detection.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[0], SCL};
            sda_sync_r <= {sda_sync_r[0], SDA_in};
            scl_prev_r <= scl_sync_r[1];
            sda_prev_r <= sda_sync_r[1];
        end
    end

    assign scl_s       = scl_sync_r[1];
    assign sda_s       = sda_sync_r[1];
    assign scl_rise_s  = scl_s & ~scl_prev_r;
    assign scl_fall_s  = ~scl_s & scl_prev_r;
    assign start_s     = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
    assign stop_s      = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
    assign addr_byte_s = {shift_r[6:0], sda_s};

    // Protocol state register and registered outputs.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            tx_shift_r <= 8'h00;
            rw_r       <= 1'b0;
            sda_oe_r   <= 1'b0;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            tx_req_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            tx_shift_r <= tx_shift_nxt_s;
            rw_r       <= rw_nxt_s;
            sda_oe_r   <= sda_oe_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rx_valid_r <= rx_valid_nxt_s;
            tx_req_r   <= tx_req_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    // Next-state and output decode; START/STOP take priority over every state.
    always_comb begin
        state_nxt_s    = state_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        tx_shift_nxt_s = tx_shift_r;
        rw_nxt_s       = rw_r;
        sda_oe_nxt_s   = sda_oe_r;
        rx_data_nxt_s  = rx_data_r;
        rx_valid_nxt_s = 1'b0;
        tx_req_nxt_s   = 1'b0;
        busy_nxt_s     = busy_r;
        if (stop_s) begin
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = 4'd0;
            sda_oe_nxt_s  = 1'b0;
            busy_nxt_s    = 1'b0;
        end else if (start_s) begin
            state_nxt_s   = ST_ADDR;
            bit_cnt_nxt_s = 4'd0;
            sda_oe_nxt_s  = 1'b0;
            busy_nxt_s    = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: sda_oe_nxt_s = 1'b0;
                ST_ADDR: begin
                    if (scl_rise_s) begin
                        shift_nxt_s = addr_byte_s;
                        if (bit_cnt_r == 4'd7) begin
                            bit_cnt_nxt_s = 4'd0;
                            rw_nxt_s      = addr_byte_s[0];
                            if (addr_match(addr_byte_s)) begin
                                state_nxt_s = ST_ADDR_ACK;
                            end else begin
                                state_nxt_s = ST_WAIT_STOP;
                            end
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        shift_nxt_s = shift_r;
                    end
                end
                ST_ADDR_ACK: begin
                    // First fall drives the ACK, the second one ends it.
                    if (scl_fall_s && !sda_oe_r) begin
                        sda_oe_nxt_s = 1'b1;
                    end else if (scl_fall_s) begin
                        bit_cnt_nxt_s = 4'd0;
                        if (rw_r) begin
                            tx_req_nxt_s   = 1'b1;
                            tx_shift_nxt_s = tx_data;
                            sda_oe_nxt_s   = ~tx_data[7];
                            state_nxt_s    = ST_RD_DATA;
                        end else begin
                            sda_oe_nxt_s = 1'b0;
                            state_nxt_s  = ST_WR_DATA;
                        end
                    end else begin
                        sda_oe_nxt_s = sda_oe_r;
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise_s && bit_cnt_r != 4'd8) begin
                        shift_nxt_s   = {shift_r[6:0], sda_s};
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
                        sda_oe_nxt_s   = 1'b1;
                        rx_data_nxt_s  = shift_r;
                        rx_valid_nxt_s = 1'b1;
                        bit_cnt_nxt_s  = 4'd0;
                        state_nxt_s    = ST_WR_ACK;
                    end else begin
                        shift_nxt_s = shift_r;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_nxt_s = 1'b0;
                        state_nxt_s  = ST_WR_DATA;
                    end else begin
                        sda_oe_nxt_s = sda_oe_r;
                    end
                end
                ST_RD_DATA: begin
                    // Bit 7 went out on entry; rotate so bit 6 is next on the bus.
                    if (scl_fall_s && bit_cnt_r == 4'd7) begin
                        sda_oe_nxt_s  = 1'b0;
                        bit_cnt_nxt_s = 4'd0;
                        state_nxt_s   = ST_RD_ACK;
                    end else if (scl_fall_s) begin
                        tx_shift_nxt_s = {tx_shift_r[6:0], tx_shift_r[7]};
                        sda_oe_nxt_s   = ~tx_shift_r[6];
                        bit_cnt_nxt_s  = bit_cnt_r + 4'd1;
                    end else begin
                        sda_oe_nxt_s = sda_oe_r;
                    end
                end
                ST_RD_ACK: begin
                    // bit_cnt == 8 marks "initiator ACKed, send another byte".
                    if (scl_rise_s && sda_s) begin
                        state_nxt_s = ST_WAIT_STOP;
                    end else if (scl_rise_s) begin
                        bit_cnt_nxt_s = 4'd8;
                    end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
                        tx_req_nxt_s   = 1'b1;
                        tx_shift_nxt_s = tx_data;
                        sda_oe_nxt_s   = ~tx_data[7];
                        bit_cnt_nxt_s  = 4'd0;
                        state_nxt_s    = ST_RD_DATA;
                    end else begin
                        sda_oe_nxt_s = 1'b0;
                    end
                end
                ST_WAIT_STOP: sda_oe_nxt_s = 1'b0;
                default: begin
                    state_nxt_s  = ST_IDLE;
                    sda_oe_nxt_s = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign tx_req   = tx_req_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C initiator around i2c_target, with a scoreboard
// for delivered write bytes and a reference model of address acceptance.
`timescale 1ns/1ps

module tb_i2c_target;

    logic       mclk = 1'b0;
    logic       rst;
    logic       scl_drv, sda_drv;
    logic       sda_bus;
    logic       sda_oe, rx_valid, tx_req, busy;
    logic [7:0] rx_data;
    logic [7:0] tx_data_drv = 8'h00;

    int checks = 0;
    int failures = 0;
    int tx_cnt = 0;
    int nd_viol = 0;
    bit nd_mon = 1'b0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] tx_feed_q[$];
    logic [7:0] wr_pat[4];
    logic [7:0] rd_pat[4];

`ifdef I2C_TARGET_GENCALL_EN
    localparam bit GEN = 1'b1;
`else
    localparam bit GEN = 1'b0;
`endif

    always #5 mclk = ~mclk;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_target #(.DEV_ADDR(7'h50)) dut (
        .mclk(mclk), .rst(rst), .SCL(scl_drv), .SDA_in(sda_bus),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data_drv), .tx_req(tx_req), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: an address byte is accepted if its upper 7 bits are 0x50,
    // or (general call enabled) if the whole byte is zero.
    function automatic bit exp_ack(input logic [7:0] a);
        return ((a >> 1) == 8'h50) || (GEN && (a == 8'h00));
    endfunction

    // Monitor: scoreboard for rx bytes, tx_req accounting, drive watch.
    always @(negedge mclk) begin : mon
        logic [7:0] e;
        if (rst) begin
            if (rx_valid) begin
                checks++;
                if (exp_rx_q.size() == 0) begin
                    failures++;
                    $display("FAIL rx_unexpected actual=%02h required=none", rx_data);
                end else begin
                    e = exp_rx_q.pop_front();
                    if (rx_data !== e) begin
                        failures++;
                        $display("FAIL rx_data actual=%02h required=%02h", rx_data, e);
                    end
                end
            end
            if (rx_valid || tx_req) chk("pulse_exclusive", {31'd0, rx_valid & tx_req}, 32'd0);
            if (tx_req) begin
                tx_cnt++;
                if (tx_feed_q.size() > 0) e = tx_feed_q.pop_front();
            end
            if (nd_mon && sda_oe) nd_viol++;
        end
        tx_data_drv = (tx_feed_q.size() > 0) ? tx_feed_q[0] : 8'h00;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    // One SCL period: drive b (1 = release), sample the bus mid-high.
    task automatic bit_xfer(input logic b, output logic s);
        sda_drv = b;  cyc(5);
        scl_drv = 1'b1; cyc(5);
        s = sda_bus;  cyc(5);
        scl_drv = 1'b0; cyc(5);
    endtask

    task automatic start_c();
        scl_drv = 1'b1; sda_drv = 1'b1; cyc(10);
        sda_drv = 1'b0; cyc(10);
        scl_drv = 1'b0; cyc(5);
    endtask

    task automatic rstart_c();
        sda_drv = 1'b1; cyc(5);
        scl_drv = 1'b1; cyc(10);
        sda_drv = 1'b0; cyc(10);
        scl_drv = 1'b0; cyc(5);
    endtask

    task automatic stop_c();
        sda_drv = 1'b0; cyc(5);
        scl_drv = 1'b1; cyc(10);
        sda_drv = 1'b1; cyc(10);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ackn);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ackn);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            d = {d[6:0], s};
        end
        bit_xfer(nack, s);
    endtask

    task automatic do_write(input logic [6:0] addr7, input int n);
        logic [7:0] a;
        logic ackn;
        bit ok;
        a = {addr7, 1'b0};
        ok = exp_ack(a);
        nd_viol = 0;
        nd_mon = !ok;
        start_c();
        chk("busy_start", {31'd0, busy}, 32'd1);
        write_byte(a, ackn);
        chk("addr_ack_w", {31'd0, ackn}, {31'd0, !ok});
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                exp_rx_q.push_back(wr_pat[i]);
                write_byte(wr_pat[i], ackn);
                chk("data_ack", {31'd0, ackn}, 32'd0);
            end
        end else begin
            write_byte(wr_pat[0], ackn);
            chk("data_nack", {31'd0, ackn}, 32'd1);
        end
        stop_c();
        chk("busy_stop", {31'd0, busy}, 32'd0);
        chk("rx_drained", exp_rx_q.size(), 32'd0);
        if (!ok) chk("no_drive", nd_viol, 32'd0);
        nd_mon = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] addr7, input int n);
        logic [7:0] a, d;
        logic ackn;
        bit ok;
        int t0;
        a = {addr7, 1'b1};
        ok = exp_ack(a);
        t0 = tx_cnt;
        nd_viol = 0;
        nd_mon = !ok;
        if (ok) for (int i = 0; i < n; i++) tx_feed_q.push_back(rd_pat[i]);
        start_c();
        write_byte(a, ackn);
        chk("addr_ack_r", {31'd0, ackn}, {31'd0, !ok});
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                read_byte(i == n - 1, d);
                chk("rd_byte", {24'd0, d}, {24'd0, rd_pat[i]});
            end
            chk("rd_release", {31'd0, sda_oe}, 32'd0);
        end
        stop_c();
        chk("tx_req_count", tx_cnt - t0, ok ? n : 0);
        chk("busy_stop_r", {31'd0, busy}, 32'd0);
        if (!ok) chk("no_drive_r", nd_viol, 32'd0);
        nd_mon = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ackn, s;
        logic [7:0] d;
        int t0;
        rst = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1;
        cyc(3);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        cyc(10);

        // Write 0xA5 to own address.
        wr_pat[0] = 8'hA5;
        do_write(7'h50, 1);
        // Wrong address.
        wr_pat[0] = 8'h77;
        do_write(7'h51, 1);
        // Read 0x3C, 0xC3 with ACK then NACK.
        rd_pat[0] = 8'h3C; rd_pat[1] = 8'hC3;
        do_read(7'h50, 2);

        // Write 0x11, then repeated START half-way into the next byte and read.
        start_c();
        write_byte(8'hA0, ackn);
        chk("rs_addr_ack", {31'd0, ackn}, 32'd0);
        exp_rx_q.push_back(8'h11);
        write_byte(8'h11, ackn);
        chk("rs_data_ack", {31'd0, ackn}, 32'd0);
        bit_xfer(1'b1, s); bit_xfer(1'b0, s); bit_xfer(1'b1, s); bit_xfer(1'b0, s);
        tx_feed_q.push_back(8'h5A);
        t0 = tx_cnt;
        rstart_c();
        write_byte(8'hA1, ackn);
        chk("rs_raddr_ack", {31'd0, ackn}, 32'd0);
        read_byte(1'b1, d);
        chk("rs_rd_byte", {24'd0, d}, 32'h5A);
        stop_c();
        chk("rs_tx_count", tx_cnt - t0, 32'd1);
        chk("rs_rx_drained", exp_rx_q.size(), 32'd0);

        // Reset in the middle of a read byte while a 0 bit is driven.
        tx_feed_q.push_back(8'h00);
        start_c();
        write_byte(8'hA1, ackn);
        chk("rst_addr_ack", {31'd0, ackn}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            bit_xfer(1'b1, s);
            chk("rst_rd_bit", {31'd0, s}, 32'd0);
        end
        chk("rst_pre_drive", {31'd0, sda_oe}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_async_sda", {31'd0, sda_oe}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_mid_pulses", {30'd0, rx_valid, tx_req}, 32'd0);
        sda_drv = 1'b1; cyc(2);
        scl_drv = 1'b1; cyc(5);
        rst = 1'b1;
        cyc(10);

        // General call write and general call read.
        wr_pat[0] = 8'h06;
        do_write(7'h00, 1);
        rd_pat[0] = 8'h99;
        do_read(7'h00, 1);

        // Randomized transactions.
        for (int k = 0; k < 12; k++) begin
            logic [6:0] ad;
            int n;
            ad = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h50;
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) begin
                wr_pat[i] = 8'($urandom);
                rd_pat[i] = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 0) do_write(ad, n);
            else do_read(ad, n);
        end

        cyc(10);
        chk("final_rx_q", exp_rx_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
